input_port_requester: RTL and testbench

//  Per-input-port initiator for the switch-control reserve/relieve protocol; one instance sits between each input FIFO and the crossbar.

---
 rtl/input_port_requester.sv | 121 ++++++++++++
 tb/tb_input_port_requester.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_port_requester.sv
// Per-input-port initiator for the switch-control reserve/relieve protocol.
// Routes the head flit XY, reserves the output, streams the packet, then relieves.
module input_port_requester #(
  parameter int unsigned N             = 4,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned REQUEST_WIDTH = 3,
  parameter int unsigned MY_X          = 0,
  parameter int unsigned MY_Y          = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WIDTH-1:0]    in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     routeReserveRequestValid,
  output logic [REQUEST_WIDTH-1:0] routeReserveRequest,
  input  logic                     routeReserveStatus,
  output logic                     routeRelieve,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [15:0]              pkt_count,
  output logic [7:0]               drop_count
);

  localparam int unsigned COORD_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned X_MSB   = DATA_WIDTH - 3;
  localparam int unsigned Y_MSB   = DATA_WIDTH - 3 - COORD_W;

  localparam logic [REQUEST_WIDTH-1:0] PORT_LOCAL = REQUEST_WIDTH'(0);
  localparam logic [REQUEST_WIDTH-1:0] PORT_NORTH = REQUEST_WIDTH'(1);
  localparam logic [REQUEST_WIDTH-1:0] PORT_EAST  = REQUEST_WIDTH'(2);
  localparam logic [REQUEST_WIDTH-1:0] PORT_SOUTH = REQUEST_WIDTH'(3);
  localparam logic [REQUEST_WIDTH-1:0] PORT_WEST  = REQUEST_WIDTH'(4);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ_WAIT = 2'd1,
    FORWARD  = 2'd2,
    RELIEVE  = 2'd3
  } state_t;

  state_t                     state, state_d;
  logic [REQUEST_WIDTH-1:0]   route_q, route_c;
  logic [1:0]                 flit_type;
  logic [COORD_W-1:0]         dest_x, dest_y;
  logic                       route_load;
  logic                       drop;

  // Type bit 0 marks a head (01/11); type bit 1 marks a packet end (10/11).
  assign flit_type = in_data[DATA_WIDTH-1 -: 2];
  assign dest_x    = in_data[X_MSB -: COORD_W];
  assign dest_y    = in_data[Y_MSB -: COORD_W];

  // Held from the request through the relieve cycle; switch control decodes relieve from it.
  assign routeReserveRequest = route_q;

  // XY dimension-order routing: resolve x first, then y.
  always_comb begin
    route_c = PORT_LOCAL;
    if (dest_x > COORD_W'(MY_X))      route_c = PORT_EAST;
    else if (dest_x < COORD_W'(MY_X)) route_c = PORT_WEST;
    else if (dest_y > COORD_W'(MY_Y)) route_c = PORT_NORTH;
    else if (dest_y < COORD_W'(MY_Y)) route_c = PORT_SOUTH;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      route_q    <= '0;
      pkt_count  <= '0;
      drop_count <= '0;
    end else begin
      state <= state_d;
      if (route_load) route_q <= route_c;
      if (routeRelieve) pkt_count <= pkt_count + 16'd1;
      if (drop && (drop_count != 8'hFF)) drop_count <= drop_count + 8'd1;
    end
  end

  // Next state and handshake outputs.
  always_comb begin
    state_d                  = state;
    in_ready                 = 1'b0;
    out_valid                = 1'b0;
    out_data                 = '0;
    routeReserveRequestValid = 1'b0;
    routeRelieve             = 1'b0;
    route_load               = 1'b0;
    drop                     = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (flit_type[0]) begin
            route_load = 1'b1;
            state_d    = REQ_WAIT;
          end else begin
            in_ready = 1'b1;
            drop     = 1'b1;
          end
        end
      end
      REQ_WAIT: begin
        routeReserveRequestValid = ~routeReserveStatus;
        if (routeReserveStatus) state_d = FORWARD;
      end
      FORWARD: begin
        out_data  = in_data;
        out_valid = in_valid;
        in_ready  = out_ready;
        if (in_valid && out_ready && flit_type[1]) state_d = RELIEVE;
      end
      RELIEVE: begin
        routeRelieve = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_input_port_requester.sv
// Directed bench for input_port_requester at MY=(1,1) in a 4x4 mesh.
module tb_input_port_requester;

  logic        clk;
  logic        rst;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        routeReserveRequestValid;
  logic [2:0]  routeReserveRequest;
  logic        routeReserveStatus;
  logic        routeRelieve;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] pkt_count;
  logic [7:0]  drop_count;

  int vectors;
  int errors;
  int relieve_cnt;
  int ncyc;
  logic [31:0] fifo[$];
  logic [31:0] outq[$];
  logic [31:0] h1, b1, b2, t1, s2, h3, t3, h4, b4a, b4b, t4, h6, b6, b6b, t6;

  input_port_requester #(
    .N(4), .DATA_WIDTH(32), .REQUEST_WIDTH(3), .MY_X(1), .MY_Y(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .routeReserveRequestValid(routeReserveRequestValid),
    .routeReserveRequest(routeReserveRequest),
    .routeReserveStatus(routeReserveStatus),
    .routeRelieve(routeRelieve),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .pkt_count(pkt_count),
    .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] flit(input logic [1:0] t, input logic [1:0] x,
                                       input logic [1:0] y, input logic [25:0] pl);
    return {t, x, y, pl};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    in_valid = (fifo.size() != 0);
    in_data  = in_valid ? fifo[0] : 32'h0;
  endtask

  // Sample handshakes mid-cycle, then advance to just after the next rising edge.
  task automatic step();
    bit pop;
    @(negedge clk);
    pop = in_valid && in_ready;
    if (out_valid && out_ready) outq.push_back(out_data);
    if (routeRelieve) relieve_cnt++;
    @(posedge clk);
    #1;
    if (pop && fifo.size() != 0) void'(fifo.pop_front());
    refresh();
  endtask

  // Runs from the first FORWARD cycle until relieve; ncyc = cycles until relieve, -1 on timeout.
  task automatic fwd(input bit toggle, input int maxc, output int n);
    n = -1;
    for (int i = 0; i < maxc; i++) begin
      out_ready = toggle ? ((i % 2) == 0) : 1'b1;
      #1;
      if (routeRelieve) begin
        n = i;
        break;
      end
      step();
    end
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors = 0; errors = 0; relieve_cnt = 0;
    rst = 1'b1; in_data = '0; in_valid = 1'b0; routeReserveStatus = 1'b0; out_ready = 1'b0;
    h1  = flit(2'b01, 2'd3, 2'd1, 26'h00000a1);
    b1  = flit(2'b00, 2'd0, 2'd0, 26'h00000b1);
    b2  = flit(2'b00, 2'd2, 2'd2, 26'h00000b2);
    t1  = flit(2'b10, 2'd1, 2'd3, 26'h00000c1);
    s2  = flit(2'b11, 2'd1, 2'd1, 26'h0000d02);
    h3  = flit(2'b01, 2'd1, 2'd3, 26'h00000a3);
    t3  = flit(2'b10, 2'd0, 2'd0, 26'h00000c3);
    h4  = flit(2'b01, 2'd0, 2'd2, 26'h00000a4);
    b4a = flit(2'b00, 2'd3, 2'd3, 26'h0000b4a);
    b4b = flit(2'b00, 2'd1, 2'd0, 26'h0000b4b);
    t4  = flit(2'b10, 2'd2, 2'd1, 26'h00000c4);
    h6  = flit(2'b01, 2'd1, 2'd0, 26'h00000a6);
    b6  = flit(2'b00, 2'd0, 2'd0, 26'h00000b6);
    b6b = flit(2'b00, 2'd0, 2'd1, 26'h0000b6b);
    t6  = flit(2'b10, 2'd0, 2'd0, 26'h00000c6);

    // Reset state
    step(); step();
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_req_valid", routeReserveRequestValid, 0);
    chk("rst_req", routeReserveRequest, 0);
    chk("rst_relieve", routeRelieve, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_pkt_count", pkt_count, 0);
    chk("rst_drop_count", drop_count, 0);
    rst = 1'b0;
    step();

    // 1: east-bound 4-flit packet, grant at cycle 3
    fifo.push_back(h1); fifo.push_back(b1); fifo.push_back(b2); fifo.push_back(t1);
    refresh(); #1;
    chk("t1_c0_req_valid", routeReserveRequestValid, 0);
    chk("t1_c0_in_ready", in_ready, 0);
    step(); #1;
    chk("t1_c1_req_valid", routeReserveRequestValid, 1);
    chk("t1_c1_req_east", routeReserveRequest, 2);
    chk("t1_c1_out_valid", out_valid, 0);
    step(); #1;
    chk("t1_c2_req_valid", routeReserveRequestValid, 1);
    step(); routeReserveStatus = 1'b1; #1;
    chk("t1_c3_req_drop", routeReserveRequestValid, 0);
    chk("t1_c3_out_valid", out_valid, 0);
    step(); routeReserveStatus = 1'b0; out_ready = 1'b1; #1;
    chk("t1_c4_out_valid", out_valid, 1);
    chk("t1_c4_head", out_data, h1);
    chk("t1_c4_in_ready", in_ready, 1);
    step(); #1; chk("t1_c5_body1", out_data, b1);
    step(); #1; chk("t1_c6_body2", out_data, b2);
    step(); #1;
    chk("t1_c7_tail", out_data, t1);
    chk("t1_c7_no_relieve", routeRelieve, 0);
    step(); #1;
    chk("t1_c8_relieve", routeRelieve, 1);
    chk("t1_c8_req_held", routeReserveRequest, 2);
    chk("t1_c8_out_valid", out_valid, 0);
    chk("t1_c8_in_ready", in_ready, 0);
    chk("t1_c8_pkt_count", pkt_count, 0);
    step(); out_ready = 1'b0; #1;
    chk("t1_c9_relieve_off", routeRelieve, 0);
    chk("t1_c9_pkt_count", pkt_count, 1);
    chk("t1_relieve_cnt", relieve_cnt, 1);

    // 2: single-flit packet to LOCAL
    fifo.push_back(s2); refresh(); #1;
    chk("t2_c0_req_valid", routeReserveRequestValid, 0);
    step(); #1;
    chk("t2_req_valid", routeReserveRequestValid, 1);
    chk("t2_req_local", routeReserveRequest, 0);
    routeReserveStatus = 1'b1; #1;
    chk("t2_req_drop", routeReserveRequestValid, 0);
    step(); routeReserveStatus = 1'b0; out_ready = 1'b1; #1;
    chk("t2_out_valid", out_valid, 1);
    chk("t2_out_data", out_data, s2);
    step(); out_ready = 1'b0; #1;
    chk("t2_relieve", routeRelieve, 1);
    chk("t2_req_held", routeReserveRequest, 0);
    step(); #1;
    chk("t2_relieve_off", routeRelieve, 0);
    chk("t2_pkt_count", pkt_count, 2);

    // 3: grant withheld 20 cycles, north-bound
    fifo.push_back(h3); fifo.push_back(t3); refresh();
    step();
    for (int i = 0; i < 20; i++) begin
      #1;
      chk("t3_wait_req_valid", routeReserveRequestValid, 1);
      chk("t3_wait_req_north", routeReserveRequest, 1);
      chk("t3_wait_out_valid", out_valid, 0);
      chk("t3_wait_in_ready", in_ready, 0);
      step();
    end
    routeReserveStatus = 1'b1; #1;
    chk("t3_nothing_popped", fifo.size(), 2);
    step(); routeReserveStatus = 1'b0;
    outq.delete();
    fwd(1'b0, 10, ncyc);
    chk("t3_relieve_cycle", ncyc, 2);
    chk("t3_out_count", outq.size(), 2);
    if (outq.size() == 2) begin
      chk("t3_out0", outq[0], h3);
      chk("t3_out1", outq[1], t3);
    end
    step(); #1;
    chk("t3_pkt_count", pkt_count, 3);

    // 4: west-bound, out_ready toggling 1010 during FORWARD
    fifo.push_back(h4); fifo.push_back(b4a); fifo.push_back(b4b); fifo.push_back(t4);
    refresh();
    step(); #1;
    chk("t4_req_west", routeReserveRequest, 4);
    routeReserveStatus = 1'b1;
    step(); routeReserveStatus = 1'b0;
    outq.delete();
    fwd(1'b1, 20, ncyc);
    chk("t4_relieve_cycle", ncyc, 7);
    chk("t4_no_early_relieve", relieve_cnt, 3);
    chk("t4_out_count", outq.size(), 4);
    if (outq.size() == 4) begin
      chk("t4_out0", outq[0], h4);
      chk("t4_out1", outq[1], b4a);
      chk("t4_out2", outq[2], b4b);
      chk("t4_out3", outq[3], t4);
    end
    step(); #1;
    chk("t4_relieve_off", routeRelieve, 0);
    chk("t4_pkt_count", pkt_count, 4);
    chk("t4_relieve_cnt", relieve_cnt, 4);

    // 5: 300 orphan flits (one tail, then bodies) dropped with saturation
    fifo.push_back(flit(2'b10, 2'd3, 2'd3, 26'h0000e00));
    for (int i = 1; i < 300; i++) fifo.push_back(flit(2'b00, 2'd3, 2'd0, 26'(i)));
    refresh();
    for (int i = 0; i < 300; i++) begin
      #1;
      chk("t5_drop_count", drop_count, (i > 255) ? 255 : i);
      chk("t5_in_ready", in_ready, 1);
      chk("t5_no_request", routeReserveRequestValid, 0);
      step();
    end
    #1;
    chk("t5_drop_sat", drop_count, 255);
    chk("t5_fifo_empty", fifo.size(), 0);
    chk("t5_in_ready_idle", in_ready, 0);
    chk("t5_pkt_count", pkt_count, 4);

    // 6: reset mid-FORWARD, south-bound
    fifo.push_back(h6); fifo.push_back(b6); fifo.push_back(b6b); fifo.push_back(t6);
    refresh();
    step(); #1;
    chk("t6_req_south", routeReserveRequest, 3);
    routeReserveStatus = 1'b1;
    step(); routeReserveStatus = 1'b0; out_ready = 1'b1; #1;
    chk("t6_head", out_data, h6);
    step(); #1;
    chk("t6_body", out_data, b6);
    rst = 1'b1;
    step();
    fifo.delete(); refresh(); out_ready = 1'b0; #1;
    chk("t6_rst_out_valid", out_valid, 0);
    chk("t6_rst_in_ready", in_ready, 0);
    chk("t6_rst_req_valid", routeReserveRequestValid, 0);
    chk("t6_rst_req", routeReserveRequest, 0);
    chk("t6_rst_relieve", routeRelieve, 0);
    chk("t6_rst_out_data", out_data, 0);
    chk("t6_rst_pkt_count", pkt_count, 0);
    chk("t6_rst_drop_count", drop_count, 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); #1;
      chk("t6_post_relieve", routeRelieve, 0);
      chk("t6_post_req_valid", routeReserveRequestValid, 0);
    end
    chk("t6_relieve_cnt", relieve_cnt, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
